// File: rtl/maxpool2x2_stream.sv
// rtl/maxpool2x2_stream.sv - streaming 2x2 stride-2 signed max-pool over a raster pixel stream
// Keeps a half-row buffer of top-row partial maxima so every input pixel is read exactly once.
module maxpool2x2_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int IMG_WIDTH  = 24,
   parameter int IMG_HEIGHT = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last
);

   localparam int HALF_W = IMG_WIDTH / 2;
   localparam int CW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int RW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int LW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic [CW-1:0]                col;
   logic [RW-1:0]                row;
   logic signed [DATA_WIDTH-1:0] hold;
   logic signed [DATA_WIDTH-1:0] px;
   logic signed [DATA_WIDTH-1:0] pm;
   logic signed [DATA_WIDTH-1:0] lb_rd;
   logic signed [DATA_WIDTH-1:0] win_max;
   logic [DATA_WIDTH-1:0]        linebuf [HALF_W];
   logic [LW-1:0]                lb_idx;
   logic                         accept;
   logic                         col_end;
   logic                         row_end;
   logic                         odd_col;
   logic                         odd_row;
   logic                         load_out;
   logic                         load_lb;

   // A held result blocks every beat, so an odd-row pixel can never overrun it.
   assign in_ready = (~out_valid | out_ready) & ~clear;
   assign accept   = in_valid & in_ready;

   assign col_end  = (col == CW'(IMG_WIDTH - 1));
   assign row_end  = (row == RW'(IMG_HEIGHT - 1));
   assign odd_col  = col[0];
   assign odd_row  = row[0];
   assign lb_idx   = LW'(col >> 1);

   assign px       = in_data;
   assign pm       = (hold > px) ? hold : px;
   assign lb_rd    = linebuf[lb_idx];
   assign win_max  = (lb_rd > pm) ? lb_rd : pm;

   assign load_out = accept & odd_col & odd_row;
   assign load_lb  = accept & odd_col & ~odd_row;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col       <= '0;
         row       <= '0;
         hold      <= MOST_NEG;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= MOST_NEG;
      end else if (clear) begin
         col       <= '0;
         row       <= '0;
         hold      <= MOST_NEG;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         if (accept) begin
            if (col_end) begin
               col <= '0;
               row <= row_end ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
            if (!odd_col) begin
               hold <= px;
            end
         end
         // A new result in the same cycle as a downstream accept replaces it seamlessly.
         if (load_out) begin
            out_valid <= 1'b1;
            out_data  <= win_max;
            out_last  <= row_end & col_end;
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

   // Contents are meaningless after reset or clear; the next even row rewrites them first.
   always_ff @(posedge clk) begin
      if (load_lb) begin
         linebuf[lb_idx] <= pm;
      end
   end

endmodule
